// File: rtl/wb_pkg.sv
// Shared types for the registered Wishbone bridge:
// FSM states, termination encoding and default widths.
package wb_pkg;

  localparam int ADDR_W_D  = 32;
  localparam int DATA_W_D  = 32;
  localparam int TIMEOUT_D = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    T_NONE,
    T_ACK,
    T_RTY,
    T_ERR
  } term_e;

  // err beats rty beats ack when several arrive together
  function automatic term_e term_prio(
    input logic err,
    input logic rty,
    input logic ack
  );
    term_e t;
    t = T_NONE;
    priority case (1'b1)
      err:     t = T_ERR;
      rty:     t = T_RTY;
      ack:     t = T_ACK;
      default: t = T_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 classic bus bundle with master/slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] rdat;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, stb, we, adr, wdat, sel,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, wdat, sel,
    output rdat, ack, err, rty
  );

endinterface

// File: rtl/wb_watchdog.sv
// Wait-cycle counter for the downstream cycle; flags the
// cycle on which the count would reach TIMEOUT.
module wb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic to_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign to_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_dut.sv
// Registered Wishbone bridge: captures an upstream request,
// replays it downstream and returns the termination a cycle later.
module wb_dut
  import wb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic clk,
  input logic rst,
  wb_if.slave  s,
  wb_if.master m
);

  state_e              state_q;
  logic                m_cyc_q, m_stb_q, m_we_q;
  logic [ADDR_W-1:0]   m_adr_q;
  logic [DATA_W-1:0]   m_dat_q;
  logic [DATA_W/8-1:0] m_sel_q;
  logic [DATA_W-1:0]   s_dat_q;
  logic                s_ack_q, s_err_q, s_rty_q;

  term_e term;
  logic  accept;
  logic  wd_to;

  assign term   = term_prio(m.err, m.rty, m.ack);
  assign accept = (state_q == IDLE) && s.cyc && s.stb;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == REQ),
    .to_o  (wd_to)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      s_dat_q <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_rty_q <= 1'b0;
    end else begin
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_rty_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            m_we_q  <= s.we;
            m_adr_q <= s.adr;
            m_dat_q <= s.wdat;
            m_sel_q <= s.sel;
            m_cyc_q <= 1'b1;
            m_stb_q <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // an upstream abort overrides any termination or timeout
          if (!s.cyc) begin
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            state_q <= IDLE;
          end else if (term != T_NONE) begin
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            s_err_q <= (term == T_ERR);
            s_rty_q <= (term == T_RTY);
            s_ack_q <= (term == T_ACK);
            if (term == T_ACK && !m_we_q)
              s_dat_q <= m.rdat;
            state_q <= RESP;
          end else if (wd_to) begin
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            s_err_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.cyc  = m_cyc_q;
  assign m.stb  = m_stb_q;
  assign m.we   = m_we_q;
  assign m.adr  = m_adr_q;
  assign m.wdat = m_dat_q;
  assign m.sel  = m_sel_q;

  assign s.rdat = s_dat_q;
  assign s.ack  = s_ack_q;
  assign s.err  = s_err_q;
  assign s.rty  = s_rty_q;

endmodule

// File: tb/tb_wb_dut.sv
// Bench for wb_dut: directed cases plus random transactions
// checked against a transaction-level model of the bridge.
module tb_wb_dut;

  localparam int TO = 16;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic [2:0]  drv;
    logic [31:0] rdata;
  } txn_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] model_rdat;

  wb_if #(.AW(32), .DW(32)) up ();
  wb_if #(.AW(32), .DW(32)) dn ();

  wb_dut #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (up),
    .m   (dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_term(input logic [2:0] drv);
    if (drv == 3'b000 || drv[2]) return 3'b100;
    if (drv[1]) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int exp_lat(input txn_t t);
    if (t.drv == 3'b000) return TO + 1;
    return t.waits + 2;
  endfunction

  function automatic logic [2:0] flags();
    return {up.err, up.rty, up.ack};
  endfunction

  task automatic drive_req(input txn_t t);
    up.cyc  = 1'b1;
    up.stb  = 1'b1;
    up.we   = t.we;
    up.adr  = t.adr;
    up.wdat = t.dat;
    up.sel  = t.sel;
  endtask

  task automatic slave_idle();
    dn.ack  = 1'b0;
    dn.err  = 1'b0;
    dn.rty  = 1'b0;
    dn.rdat = $urandom;
  endtask

  task automatic run(input txn_t t, input bit b2b, input txn_t nt);
    bit         seen;
    logic [2:0] ex;
    int         lat;
    ex   = exp_term(t.drv);
    lat  = exp_lat(t);
    seen = 1'b0;
    drive_req(t);
    slave_idle();
    for (int i = 0; i <= TO + 4 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        check("req_cycstb", {dn.cyc, dn.stb}, 2'b11);
        check("req_we", dn.we, t.we);
        check("req_adr", dn.adr, t.adr);
        check("req_dat", dn.wdat, t.dat);
        check("req_sel", dn.sel, t.sel);
      end
      if (flags() != 3'b000) begin
        seen = 1'b1;
        if (!t.we && ex == 3'b001) model_rdat = t.rdata;
        check("latency", i + 1, lat);
        check("term", flags(), ex);
        check("mcyc_drop", {dn.cyc, dn.stb}, 2'b00);
        check("sdat", up.rdat, model_rdat);
        slave_idle();
      end else if (t.drv != 3'b000 && i == t.waits) begin
        {dn.err, dn.rty, dn.ack} = t.drv;
        dn.rdat = t.rdata;
      end else begin
        slave_idle();
      end
    end
    check("term_seen", seen, 1'b1);
    slave_idle();
    if (b2b) begin
      drive_req(nt);
    end else begin
      up.cyc = 1'b0;
      up.stb = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("pulse_one", flags(), 3'b000);
    check("sdat_hold", up.rdat, model_rdat);
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel,
                              input int waits, input logic [2:0] drv,
                              input logic [31:0] rdata);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
    t.waits = waits; t.drv = drv; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    int   r;
    t.we    = 1'($urandom);
    t.adr   = $urandom;
    t.dat   = $urandom;
    t.sel   = 4'($urandom);
    t.rdata = $urandom;
    t.waits = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 4);
    r = $urandom_range(0, 11);
    case (r)
      0:       t.drv = 3'b000;
      1:       t.drv = 3'b100;
      2:       t.drv = 3'b110;
      3:       t.drv = 3'b101;
      4:       t.drv = 3'b010;
      5:       t.drv = 3'b011;
      default: t.drv = 3'b001;
    endcase
    return t;
  endfunction

  txn_t tq[$];
  txn_t a, b, dummy;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_rdat = '0;
    rst = 1'b0;
    up.cyc = 1'b0; up.stb = 1'b0; up.we = 1'b0;
    up.adr = '0; up.wdat = '0; up.sel = '0;
    slave_idle();
    dummy = mk(1'b0, 0, 0, 0, 0, 3'b001, 0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_mctl", {dn.cyc, dn.stb, dn.we}, 3'b000);
    check("rst_madr", dn.adr, 32'h0);
    check("rst_mdat", dn.wdat, 32'h0);
    check("rst_msel", dn.sel, 4'h0);
    check("rst_sterm", flags(), 3'b000);
    check("rst_sdat", up.rdat, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_mcyc", {dn.cyc, dn.stb}, 2'b00);
    check("post_rst_term", flags(), 3'b000);

    run(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 3'b001, 32'h1234), 1'b0, dummy);
    run(mk(1'b0, 32'h20, 32'h0, 4'hF, 3, 3'b001, 32'hCAFEF00D), 1'b0, dummy);
    run(mk(1'b1, 32'h24, 32'h55AA55AA, 4'h3, 1, 3'b001, 32'h77777777), 1'b0, dummy);
    run(mk(1'b0, 32'h30, 32'h0, 4'hF, 2, 3'b101, 32'h11111111), 1'b0, dummy);
    run(mk(1'b0, 32'h34, 32'h0, 4'hF, 0, 3'b010, 32'h22222222), 1'b0, dummy);
    run(mk(1'b0, 32'h38, 32'h0, 4'hF, 0, 3'b000, 32'h33333333), 1'b0, dummy);

    // upstream abort coinciding with a downstream ack
    a = mk(1'b0, 32'h40, 32'h0, 4'hF, 0, 3'b001, 32'h44444444);
    drive_req(a);
    slave_idle();
    @(posedge clk);
    @(negedge clk);
    check("abort_req", dn.cyc, 1'b1);
    up.cyc = 1'b0;
    up.stb = 1'b0;
    dn.ack = 1'b1;
    dn.rdat = 32'h44444444;
    @(posedge clk);
    @(negedge clk);
    check("abort_mcyc", {dn.cyc, dn.stb}, 2'b00);
    check("abort_term", flags(), 3'b000);
    slave_idle();
    @(posedge clk);
    @(negedge clk);
    check("abort_term2", flags(), 3'b000);
    check("abort_sdat", up.rdat, model_rdat);

    a = mk(1'b1, 32'h50, 32'hA5A5A5A5, 4'hC, 0, 3'b001, 32'h0);
    b = mk(1'b1, 32'h54, 32'h5A5A5A5A, 4'h1, 0, 3'b001, 32'h0);
    run(a, 1'b1, b);
    run(b, 1'b0, dummy);

    for (int k = 0; k < 40; k++) tq.push_back(rnd());
    for (int k = 0; k < 40; k++) begin
      bit bb;
      bb = (k + 1 < 40) && ($urandom_range(0, 1) == 1);
      run(tq[k], bb, (k + 1 < 40) ? tq[k + 1] : dummy);
    end

    // asynchronous reset in the middle of a downstream cycle
    a = mk(1'b0, 32'h60, 32'h0, 4'hF, 0, 3'b000, 32'h0);
    drive_req(a);
    slave_idle();
    @(posedge clk);
    @(negedge clk);
    check("mid_req", dn.cyc, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mcyc", {dn.cyc, dn.stb}, 2'b00);
    check("mid_rst_sdat", up.rdat, 32'h0);
    up.cyc = 1'b0;
    up.stb = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_term", flags(), 3'b000);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_after", {dn.cyc, flags()}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
